// File: rtl/b16_mac_pkg.sv
// ----------------------------------------------------------------------------
// b16_mac_pkg
//   Shared definitions for the b16 bit-serial MAC datapath.
//   - B16_LANES / B16_PREC / B16_PW : default lane count, word precision and
//     width of a precision field ($clog2(PREC)+1).
//   - state_t with ST_IDLE / ST_SEND : serializer FSM encoding.
// ----------------------------------------------------------------------------
package b16_mac_pkg;

    localparam int B16_LANES = 16;
    localparam int B16_PREC  = 16;
    localparam int B16_PW    = 5;

    typedef logic state_t;

    localparam state_t ST_IDLE = 1'b0;  // active buffer empty
    localparam state_t ST_SEND = 1'b1;  // active buffer holds a vector being sent

endpackage

// File: rtl/b16_bitplane_select.sv
// ----------------------------------------------------------------------------
// b16_bitplane_select
//   Combinational column mux: picks bit bit_idx_i of every lane word and packs
//   the results into one LANES-wide bit-plane. Shared by the activation and
//   weight serializers.
//   Ports:
//     words_i   [LANES*PREC]  lane k word = words_i[k*PREC +: PREC]
//     bit_idx_i [IW]          column (bit position) to extract
//     plane_o   [LANES]       plane_o[k] = lane k word[bit_idx_i]
// ----------------------------------------------------------------------------
module b16_bitplane_select #(
    parameter int LANES = 16,
    parameter int PREC  = 16,
    parameter int IW    = 4
) (
    input  logic [LANES*PREC-1:0] words_i,
    input  logic [IW-1:0]         bit_idx_i,
    output logic [LANES-1:0]      plane_o
);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [PREC-1:0] lane_word;
        assign lane_word  = words_i[k*PREC +: PREC];
        assign plane_o[k] = lane_word[bit_idx_i];
    end

endmodule

// File: rtl/b16_bitplane_serializer.sv
// ----------------------------------------------------------------------------
// b16_bitplane_serializer
//   Transmit side of the bit-serial MAC: takes a vector of LANES words and
//   emits one LANES-wide bit-plane per cycle, MSB plane first, with first/last
//   markers. An active + shadow buffer pair lets vectors stream back-to-back
//   with no bubble cycles.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     in_valid      input vector valid
//     in_ready      vector can be accepted (shadow buffer empty)
//     in_words      LANES*PREC packed lane words
//     in_prec       bits to send, 1..PREC; 0 or >PREC means PREC
//     out_valid     out_plane holds a valid plane
//     out_ready     downstream accepts the plane
//     out_plane     bit k = lane k word[bit_idx]
//     out_first     MSB plane of a vector
//     out_last      bit 0 plane of a vector
//     busy          active or shadow buffer occupied
// ----------------------------------------------------------------------------
module b16_bitplane_serializer
    import b16_mac_pkg::*;
#(
    parameter int LANES = B16_LANES,
    parameter int PREC  = B16_PREC,
    parameter int PW    = B16_PW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*PREC-1:0] in_words,
    input  logic [PW-1:0]         in_prec,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      out_plane,
    output logic                  out_first,
    output logic                  out_last,
    output logic                  busy
);

    localparam int IW = (PREC > 1) ? $clog2(PREC) : 1;

    // Out-of-range precision requests fall back to full precision.
    function automatic logic [PW-1:0] eff_prec(input logic [PW-1:0] p);
        if (p == '0 || p > PW'(PREC)) begin
            return PW'(PREC);
        end
        return p;
    endfunction

    // ------------------------------------------------------------------
    // State and buffers
    // ------------------------------------------------------------------
    state_t                  state_q,     state_d;
    logic [LANES*PREC-1:0]   act_words_q, act_words_d;
    logic [PW-1:0]           act_prec_q,  act_prec_d;
    logic [PW-1:0]           bit_idx_q,   bit_idx_d;
    logic [LANES*PREC-1:0]   shd_words_q, shd_words_d;
    logic [PW-1:0]           shd_prec_q,  shd_prec_d;
    logic                    shd_full_q,  shd_full_d;

    // Control strobes from the FSM to the datapath
    logic                    xfer;        // input handshake this cycle
    logic                    adv;         // plane handshake this cycle
    logic                    vec_done;    // last plane of active vector accepted
    logic                    load_act;    // input vector goes straight into active
    logic                    promote;     // shadow moves into active
    logic                    dec_idx;     // step to next lower bit
    logic [PW-1:0]           in_prec_eff;
    logic [LANES-1:0]        sel_plane;

    assign xfer        = in_valid && !shd_full_q;
    assign adv         = (state_q == ST_SEND) && out_ready;
    assign vec_done    = adv && (bit_idx_q == '0);
    assign in_prec_eff = eff_prec(in_prec);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        load_act = 1'b0;
        promote  = 1'b0;
        dec_idx  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    load_act = 1'b1;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (adv) begin
                    if (!vec_done) begin
                        dec_idx = 1'b1;
                    end else if (shd_full_q) begin
                        promote = 1'b1;
                    end else if (xfer) begin
                        // Handoff on the last plane: no IDLE cycle in between.
                        load_act = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Buffer / counter next values
    // ------------------------------------------------------------------
    always_comb begin
        act_words_d = act_words_q;
        act_prec_d  = act_prec_q;
        bit_idx_d   = bit_idx_q;
        shd_words_d = shd_words_q;
        shd_prec_d  = shd_prec_q;
        shd_full_d  = shd_full_q;

        if (dec_idx) begin
            bit_idx_d = bit_idx_q - PW'(1);
        end

        if (promote) begin
            act_words_d = shd_words_q;
            act_prec_d  = shd_prec_q;
            bit_idx_d   = shd_prec_q - PW'(1);
            shd_full_d  = 1'b0;
        end

        // An accepted vector not taken by active lands in the shadow.
        // xfer implies the shadow is empty, so this never collides with promote.
        if (load_act) begin
            act_words_d = in_words;
            act_prec_d  = in_prec_eff;
            bit_idx_d   = in_prec_eff - PW'(1);
        end else if (xfer) begin
            shd_words_d = in_words;
            shd_prec_d  = in_prec_eff;
            shd_full_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_words_q <= '0;
            act_prec_q  <= '0;
            bit_idx_q   <= '0;
            shd_words_q <= '0;
            shd_prec_q  <= '0;
            shd_full_q  <= 1'b0;
        end else begin
            act_words_q <= act_words_d;
            act_prec_q  <= act_prec_d;
            bit_idx_q   <= bit_idx_d;
            shd_words_q <= shd_words_d;
            shd_prec_q  <= shd_prec_d;
            shd_full_q  <= shd_full_d;
        end
    end

    // ------------------------------------------------------------------
    // Column select of the active buffer
    // ------------------------------------------------------------------
    b16_bitplane_select #(
        .LANES (LANES),
        .PREC  (PREC),
        .IW    (IW)
    ) u_select (
        .words_i   (act_words_q),
        .bit_idx_i (bit_idx_q[IW-1:0]),
        .plane_o   (sel_plane)
    );

    // ------------------------------------------------------------------
    // Outputs: derived only from registers, so no in->out combinational path
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = !shd_full_q;
        out_valid = (state_q == ST_SEND);
        out_plane = out_valid ? sel_plane : '0;
        out_first = out_valid && (bit_idx_q == act_prec_q - PW'(1));
        out_last  = out_valid && (bit_idx_q == '0);
        busy      = out_valid || shd_full_q;
    end

endmodule
